// File: rtl/instrumented_adder_seq.sv
// ---------------------------------------------------------------------------
// instrumented_adder_seq
//
// Measurement sequencer for the instrumented 32-bit adder. A measurement
// latches the operands and the active-low bit selects onto the adder, waits
// for the adder to settle, then closes the ring oscillator for a programmed
// number of cycles. While the ring runs and for a short drain afterwards,
// rising edges of the (asynchronous) chain_out signal are synchronised and
// counted into a saturating counter.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start                     level request, only looked at while idle
//   abort                     synchronous abort, honoured in any busy state
//   a_value, b_value          operands to present to the adder
//   ring_sel_b, ext_sel_b,
//   sout_sel_b                active-low ring / external / sum-output selects
//   window                    number of cycles the ring is closed
//   chain_out                 asynchronous ring output coming back from the adder
//   cont                      (optional) keep re-measuring while high
//   a_input, b_input          registered operands towards the adder
//   a_input_ring_bit_b,
//   a_input_ext_bit_b,
//   s_output_bit_b            registered selects towards the adder
//   ring_en                   closes the ring loop
//   busy                      high whenever the sequencer is not idle
//   done                      one-cycle completion pulse
//   aborted                   sticky, cleared when the next measurement loads
//   count                     saturating edge count, held until the next load
//   overflow                  sticky, set when an edge arrives at full count
//
// Build option
//   INSTR_SEQ_CONTINUOUS_EN   adds the cont input; with cont high the
//                             sequencer loops from DONE straight back to LOAD.
// ---------------------------------------------------------------------------
module instrumented_adder_seq #(
   parameter int WIDTH         = 32,
   parameter int CNT_W         = 24,
   parameter int WIN_W         = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a_value,
   input  logic [WIDTH-1:0]   b_value,
   input  logic [WIDTH-1:0]   ring_sel_b,
   input  logic [WIDTH-1:0]   ext_sel_b,
   input  logic [WIDTH-1:0]   sout_sel_b,
   input  logic [WIN_W-1:0]   window,
   input  logic               chain_out,
`ifdef INSTR_SEQ_CONTINUOUS_EN
   input  logic               cont,
`endif
   output logic [WIDTH-1:0]   a_input,
   output logic [WIDTH-1:0]   b_input,
   output logic [WIDTH-1:0]   a_input_ring_bit_b,
   output logic [WIDTH-1:0]   a_input_ext_bit_b,
   output logic [WIDTH-1:0]   s_output_bit_b,
   output logic               ring_en,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [CNT_W-1:0]   count,
   output logic               overflow
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      RUN,
      DRAIN,
      DONE
   } SeqState;

   localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
   localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   SeqState                state;
   logic [WIN_W-1:0]       phaseCnt;
   logic [WIN_W-1:0]       windowReg;
   logic [SYNC_STAGES-1:0] syncReg;
   logic                   prevLast;
   logic                   chainRise;
   logic                   countEnable;
   logic                   loopAgain;

   // Whether DONE should roll straight into another measurement. Without the
   // continuous option every measurement is a single shot.
`ifdef INSTR_SEQ_CONTINUOUS_EN
   assign loopAgain = cont;
`else
   assign loopAgain = 1'b0;
`endif

   // chain_out is asynchronous to our clock, so it goes through a plain flop
   // chain before we look at it. We also keep the previous value of the last
   // stage so that a rising edge is seen as a 0 -> 1 step of that stage.
   // These flops run all the time; only the counting itself is gated.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         syncReg  <= '0;
         prevLast <= 1'b0;
      end else begin
         syncReg  <= {syncReg[SYNC_STAGES-2:0], chain_out};
         prevLast <= syncReg[SYNC_STAGES-1];
      end
   end

   // A rise only counts while the ring is closed or while edges that were
   // already inside the synchroniser are still arriving (the drain phase).
   assign chainRise   = syncReg[SYNC_STAGES-1] & ~prevLast;
   assign countEnable = (state == RUN) || (state == DRAIN);

   // Main sequencer. All outputs are registered here so the adder only ever
   // sees clean flop outputs. phaseCnt counts down the remaining cycles of
   // whichever timed phase we are in (settle, run or drain) and reaching zero
   // moves us on. An abort outside IDLE overrides everything else, leaving the
   // operands, selects and partial count where they are so they can be read.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state              <= IDLE;
         phaseCnt           <= '0;
         windowReg          <= '0;
         a_input            <= '0;
         b_input            <= '0;
         a_input_ring_bit_b <= '1;
         a_input_ext_bit_b  <= '1;
         s_output_bit_b     <= '1;
         ring_en            <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         aborted            <= 1'b0;
         count              <= '0;
         overflow           <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && (state != IDLE)) begin
            state   <= IDLE;
            ring_en <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
         end else begin
            if (countEnable && chainRise) begin
               if (count == CNT_MAX) begin
                  overflow <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  a_input            <= a_value;
                  b_input            <= b_value;
                  a_input_ring_bit_b <= ring_sel_b;
                  a_input_ext_bit_b  <= ext_sel_b;
                  s_output_bit_b     <= sout_sel_b;
                  windowReg          <= window;
                  count              <= '0;
                  overflow           <= 1'b0;
                  aborted            <= 1'b0;
                  phaseCnt           <= SETTLE_LAST;
                  state              <= SETTLE;
               end
               SETTLE: begin
                  if (phaseCnt != '0) begin
                     phaseCnt <= phaseCnt - 1'b1;
                  end else if (windowReg == '0) begin
                     phaseCnt <= DRAIN_LAST;
                     state    <= DRAIN;
                  end else begin
                     phaseCnt <= windowReg - 1'b1;
                     ring_en  <= 1'b1;
                     state    <= RUN;
                  end
               end
               RUN: begin
                  if (phaseCnt != '0) begin
                     phaseCnt <= phaseCnt - 1'b1;
                  end else begin
                     phaseCnt <= DRAIN_LAST;
                     ring_en  <= 1'b0;
                     state    <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (phaseCnt != '0) begin
                     phaseCnt <= phaseCnt - 1'b1;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
               DONE: begin
                  if (loopAgain) begin
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  ring_en <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
